// File: rtl/apb_demux_pkg.sv
// ---------------------------------------------------------------------------
// apb_demux_pkg
// Shared types and constants for the APB3 1-to-N address demultiplexer.
//   state_e   : transfer-phase state (IDLE / SETUP / ACCESS / ERR)
//   IDX_W     : completer index width for the default completer count
//   idx_width : index width for any completer count (at least 1 bit)
// ---------------------------------------------------------------------------
package apb_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam int unsigned DEF_SLAVE_COUNT = 32'd3;
  localparam int unsigned IDX_W           = $clog2(DEF_SLAVE_COUNT);

  // A single completer still needs a 1-bit index vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/apb_if.sv
// ---------------------------------------------------------------------------
// apb_if
// APB3 bus bundle used on both sides of the demultiplexer.
//   apb_s : upstream completer view (PADDR/PSEL/PENABLE/PWRITE/PWDATA in,
//           PRDATA/PREADY/PSLVERR out)
//   apb_m : downstream requester view (PADDR/PSELx/PENABLE/PWRITE/PWDATA out,
//           per-completer PRDATAx/PREADYx/PSLVERRx in)
// ---------------------------------------------------------------------------
interface apb_if #(
  parameter int unsigned SLAVE_COUNT = 32'd3,
  parameter int unsigned ADDR_W      = 32'd32,
  parameter int unsigned DATA_W      = 32'd32
);

  logic [ADDR_W-1:0]                  PADDR;
  logic                               PSEL;
  logic                               PENABLE;
  logic                               PWRITE;
  logic [DATA_W-1:0]                  PWDATA;
  logic [DATA_W-1:0]                  PRDATA;
  logic                               PREADY;
  logic                               PSLVERR;

  logic [SLAVE_COUNT-1:0]             PSELx;
  logic [SLAVE_COUNT-1:0][DATA_W-1:0] PRDATAx;
  logic [SLAVE_COUNT-1:0]             PREADYx;
  logic [SLAVE_COUNT-1:0]             PSLVERRx;

  modport apb_s (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

  modport apb_m (
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    input  PRDATAx, PREADYx, PSLVERRx
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Combinational PADDR decode into completer regions of 2**REGION_BITS bytes
// starting at BASE_ADDR.
//   addr_i   : requester address
//   hit_o    : address falls inside one of the SLAVE_COUNT regions
//   idx_o    : region index (meaningful only when hit_o)
//   onehot_o : one-hot select, all zero when unmapped
// ---------------------------------------------------------------------------
module apb_addr_decoder #(
  parameter int unsigned       SLAVE_COUNT = 32'd3,
  parameter int unsigned       ADDR_W      = 32'd32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       REGION_BITS = 32'd12,
  parameter int unsigned       IDX_W       = 32'd2
) (
  input  logic [ADDR_W-1:0]      addr_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [SLAVE_COUNT-1:0] onehot_o
);

  logic              borrow_s;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] region_s;

  // Region decode; the subtraction borrow flags addresses below the window.
  always_comb begin
    {borrow_s, offset_s} = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    region_s = offset_s >> REGION_BITS;
    hit_o    = !borrow_s && (region_s < ADDR_W'(SLAVE_COUNT));
    idx_o    = region_s[IDX_W-1:0];
    onehot_o = '0;
    for (int i = 0; i < int'(SLAVE_COUNT); i++) begin
      onehot_o[i] = hit_o && (region_s == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/apb_demux_top.sv
// ---------------------------------------------------------------------------
// apb_demux_top
// APB3 1-to-SLAVE_COUNT address demultiplexer.
//   PCLK    : clock, all state on the rising edge
//   PRESETn : asynchronous active-low reset
//   slv     : upstream port (this block is the completer)
//   mstr    : downstream port (this block is the requester)
// PADDR/PWRITE/PWDATA pass straight through. PSELx is the live decode during
// the setup phase and the latched index during the access phase. Unmapped
// accesses get a single-cycle local PSLVERR response.
// ---------------------------------------------------------------------------
module apb_demux_top
  import apb_demux_pkg::*;
#(
  parameter int unsigned       SLAVE_COUNT = 32'd3,
  parameter int unsigned       ADDR_W      = 32'd32,
  parameter int unsigned       DATA_W      = 32'd32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       REGION_BITS = 32'd12
) (
  input  logic PCLK,
  input  logic PRESETn,
  apb_if.apb_s slv,
  apb_if.apb_m mstr
);

  localparam int unsigned IDX_L = idx_width(SLAVE_COUNT);

  state_e                 state_q, state_d, cur_state_s;
  logic [IDX_L-1:0]       idx_q, idx_d;

  logic                   dec_hit_s;
  logic [IDX_L-1:0]       dec_idx_s;
  logic [SLAVE_COUNT-1:0] dec_onehot_s;

  logic [SLAVE_COUNT-1:0] idx_oh_s;
  logic                   sel_ready_s;
  logic                   sel_err_s;
  logic [DATA_W-1:0]      sel_rdata_s;

  apb_addr_decoder #(
    .SLAVE_COUNT (SLAVE_COUNT),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS),
    .IDX_W       (IDX_L)
  ) u_dec (
    .addr_i   (slv.PADDR),
    .hit_o    (dec_hit_s),
    .idx_o    (dec_idx_s),
    .onehot_o (dec_onehot_s)
  );

  // State and latched completer index.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Effective phase of the current cycle. A setup phase is recognised from the
  // live bus, so it never costs a cycle even straight after a completed
  // transfer (back-to-back). Reset forces IDLE so every output drops at once.
  always_comb begin
    if (!PRESETn) begin
      cur_state_s = ST_IDLE;
    end else if ((state_q == ST_IDLE) && slv.PSEL && !slv.PENABLE) begin
      cur_state_s = ST_SETUP;
    end else begin
      cur_state_s = state_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (cur_state_s)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (dec_hit_s) begin
          state_d = ST_ACCESS;
          idx_d   = dec_idx_s;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_ACCESS: begin
        // Completion (or an abandoned transfer) returns to IDLE; a following
        // setup phase is picked up combinationally from there.
        if (sel_ready_s || !slv.PSEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response mux from the latched completer; others are masked off.
  always_comb begin
    idx_oh_s    = '0;
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < int'(SLAVE_COUNT); i++) begin
      idx_oh_s[i] = (idx_q == IDX_L'(i));
      sel_ready_s = sel_ready_s | (mstr.PREADYx[i] & idx_oh_s[i]);
      sel_err_s   = sel_err_s | (mstr.PSLVERRx[i] & idx_oh_s[i]);
      sel_rdata_s = sel_rdata_s | (mstr.PRDATAx[i] & {DATA_W{idx_oh_s[i]}});
    end
  end

  // Bus outputs per phase plus zero-latency request forwarding.
  always_comb begin
    mstr.PADDR   = slv.PADDR;
    mstr.PWRITE  = slv.PWRITE;
    mstr.PWDATA  = slv.PWDATA;
    mstr.PSELx   = '0;
    mstr.PENABLE = 1'b0;
    slv.PREADY   = 1'b0;
    slv.PSLVERR  = 1'b0;
    slv.PRDATA   = '0;
    case (cur_state_s)
      ST_IDLE: begin
        mstr.PSELx = '0;
      end
      ST_SETUP: begin
        mstr.PSELx = dec_onehot_s;
      end
      ST_ACCESS: begin
        mstr.PSELx   = idx_oh_s;
        mstr.PENABLE = slv.PENABLE;
        slv.PREADY   = sel_ready_s;
        slv.PSLVERR  = sel_err_s;
        slv.PRDATA   = sel_rdata_s;
      end
      ST_ERR: begin
        slv.PREADY  = 1'b1;
        slv.PSLVERR = 1'b1;
      end
      default: begin
        mstr.PSELx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_demux_top.sv
// ---------------------------------------------------------------------------
// tb_apb_demux_top
// Directed and randomized transfers against apb_demux_top (3 completers,
// 4 KiB regions at base 0). Expected values come from an address-map model
// computed arithmetically from the region rules.
// ---------------------------------------------------------------------------
module tb_apb_demux_top;

  localparam int unsigned NS   = 3;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned RB   = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam longint      RSZ  = 64'd4096;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always #5 PCLK = ~PCLK;

  apb_if #(.SLAVE_COUNT(NS), .ADDR_W(AW), .DATA_W(DW)) up_if ();
  apb_if #(.SLAVE_COUNT(NS), .ADDR_W(AW), .DATA_W(DW)) dn_if ();

  apb_demux_top #(
    .SLAVE_COUNT (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BASE_ADDR   (BASE),
    .REGION_BITS (RB)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .slv     (up_if),
    .mstr    (dn_if)
  );

  // Address map: completer number, or -1 when unmapped.
  function automatic int exp_slave(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    if (d < 0) return -1;
    if ((d / RSZ) >= longint'(NS)) return -1;
    return int'(d / RSZ);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Completer k answers with the given values; all others answer noise.
  task automatic drive_resp(input int k, input logic rdy, input logic [31:0] rd, input logic er);
    for (int i = 0; i < int'(NS); i++) begin
      dn_if.PREADYx[i]  = (i == k) ? rdy : 1'($urandom);
      dn_if.PRDATAx[i]  = (i == k) ? rd  : $urandom;
      dn_if.PSLVERRx[i] = (i == k) ? er  : 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1;
      up_if.PSEL    = 1'b0;
      up_if.PENABLE = 1'b0;
      drive_resp(-1, 1'b0, 32'h0, 1'b0);
      @(negedge PCLK);
      chk("idle_psel",   32'(dn_if.PSELx),  32'h0);
      chk("idle_pready", 32'(up_if.PREADY), 32'h0);
    end
  endtask

  // One complete APB transfer; the completer inserts 'waits' wait states.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic er, input string tag);
    int         k;
    logic [2:0] oh;
    logic       rdy_exp;
    k  = exp_slave(a);
    oh = 3'b000;
    if (k >= 0) oh[k] = 1'b1;
    @(posedge PCLK); #1;
    up_if.PSEL    = 1'b1;
    up_if.PENABLE = 1'b0;
    up_if.PADDR   = a;
    up_if.PWRITE  = wr;
    up_if.PWDATA  = wd;
    drive_resp(k, 1'($urandom), rd, er);
    @(negedge PCLK);
    chk({tag, "/setup_psel"},    32'(dn_if.PSELx),   32'(oh));
    chk({tag, "/setup_penable"}, 32'(dn_if.PENABLE), 32'h0);
    chk({tag, "/setup_pready"},  32'(up_if.PREADY),  32'h0);
    chk({tag, "/setup_pslverr"}, 32'(up_if.PSLVERR), 32'h0);
    chk({tag, "/setup_prdata"},  up_if.PRDATA,       32'h0);
    chk({tag, "/fwd_paddr"},     dn_if.PADDR,        a);
    chk({tag, "/fwd_pwrite"},    32'(dn_if.PWRITE),  32'(wr));
    for (int c = 0; c <= waits; c++) begin
      @(posedge PCLK); #1;
      up_if.PENABLE = 1'b1;
      drive_resp(k, (c >= waits), rd, er);
      @(negedge PCLK);
      rdy_exp = (k < 0) ? 1'b1 : (c >= waits);
      chk({tag, "/acc_psel"},    32'(dn_if.PSELx),   32'(oh));
      chk({tag, "/acc_penable"}, 32'(dn_if.PENABLE), 32'(k >= 0));
      chk({tag, "/acc_pready"},  32'(up_if.PREADY),  32'(rdy_exp));
      chk({tag, "/acc_pslverr"}, 32'(up_if.PSLVERR), 32'((k < 0) ? 1'b1 : er));
      chk({tag, "/acc_prdata"},  up_if.PRDATA,       (k < 0) ? 32'h0 : rd);
      chk({tag, "/fwd_pwdata"},  dn_if.PWDATA,       wd);
      if (rdy_exp) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, r;
    int          cls;

    // Reset held with a setup phase on the bus: nothing may leak out.
    up_if.PSEL    = 1'b1;
    up_if.PENABLE = 1'b0;
    up_if.PADDR   = 32'h0000_1000;
    up_if.PWRITE  = 1'b0;
    up_if.PWDATA  = 32'h0;
    drive_resp(-1, 1'b0, 32'h0, 1'b0);
    #12;
    chk("rst_psel",    32'(dn_if.PSELx),   32'h0);
    chk("rst_penable", 32'(dn_if.PENABLE), 32'h0);
    chk("rst_pready",  32'(up_if.PREADY),  32'h0);
    chk("rst_pslverr", 32'(up_if.PSLVERR), 32'h0);
    chk("rst_prdata",  up_if.PRDATA,       32'h0);
    up_if.PSEL = 1'b0;
    #13;
    PRESETn = 1'b1;
    idle(2);

    xfer(32'h0000_100C, 1'b1, 32'h0000_0032, 1, 32'h1111_2222, 1'b0, "wr_s1");
    idle(1);
    xfer(32'h0000_2004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "rd_s2");
    idle(1);
    xfer(32'h0000_3000, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b0, "unmapped");
    idle(1);
    xfer(32'h0000_0010, 1'b1, 32'hCAFE_0010, 2, 32'h0, 1'b0, "wait2");
    idle(1);
    xfer(32'h0000_0FFC, 1'b0, 32'h0, 0, 32'h0000_0FFC, 1'b0, "b2b_a");
    xfer(32'h0000_1000, 1'b0, 32'h0, 0, 32'h0000_1000, 1'b1, "b2b_b");
    idle(1);
    xfer(32'h0000_2FFF, 1'b0, 32'h0, 1, 32'h0000_2FFF, 1'b0, "last_byte");
    xfer(32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 0, 32'h0, 1'b0, "top_addr");
    idle(1);

    // Protocol violations are ignored.
    @(posedge PCLK); #1;
    up_if.PSEL    = 1'b0;
    up_if.PENABLE = 1'b1;
    @(negedge PCLK);
    chk("viol_nosel_psel",   32'(dn_if.PSELx),  32'h0);
    chk("viol_nosel_pready", 32'(up_if.PREADY), 32'h0);
    @(posedge PCLK); #1;
    up_if.PSEL = 1'b1;
    @(negedge PCLK);
    chk("viol_nosetup_psel",   32'(dn_if.PSELx),  32'h0);
    chk("viol_nosetup_pready", 32'(up_if.PREADY), 32'h0);
    idle(1);

    // Reset in the middle of an access to completer 2.
    @(posedge PCLK); #1;
    up_if.PSEL    = 1'b1;
    up_if.PENABLE = 1'b0;
    up_if.PADDR   = 32'h0000_2010;
    drive_resp(2, 1'b0, 32'h0BAD_F00D, 1'b0);
    @(posedge PCLK); #1;
    up_if.PENABLE = 1'b1;
    drive_resp(2, 1'b0, 32'h0BAD_F00D, 1'b0);
    @(negedge PCLK);
    chk("midrst_acc_psel", 32'(dn_if.PSELx), 32'h4);
    #2;
    PRESETn = 1'b0;
    drive_resp(2, 1'b1, 32'h0BAD_F00D, 1'b1);
    #1;
    chk("midrst_psel",    32'(dn_if.PSELx),   32'h0);
    chk("midrst_penable", 32'(dn_if.PENABLE), 32'h0);
    chk("midrst_pready",  32'(up_if.PREADY),  32'h0);
    chk("midrst_pslverr", 32'(up_if.PSLVERR), 32'h0);
    @(posedge PCLK); #1;
    up_if.PSEL    = 1'b0;
    up_if.PENABLE = 1'b0;
    #2;
    PRESETn = 1'b1;
    idle(1);
    // After release the FSM must be idle: an access phase with no setup is ignored.
    @(posedge PCLK); #1;
    up_if.PSEL    = 1'b1;
    up_if.PENABLE = 1'b1;
    drive_resp(2, 1'b1, 32'h0BAD_F00D, 1'b0);
    @(negedge PCLK);
    chk("postrst_psel",   32'(dn_if.PSELx),  32'h0);
    chk("postrst_pready", 32'(up_if.PREADY), 32'h0);
    idle(1);
    xfer(32'h0000_2020, 1'b0, 32'h0, 0, 32'h2020_2020, 1'b0, "postrst_rd");

    // Randomized transfers over mapped, boundary and unmapped addresses.
    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 5));
      r   = $urandom;
      case (cls)
        0, 1, 2: a = (32'(cls) << RB) + {20'h0, r[11:0]};
        3:       a = 32'h0000_3000 + {16'h0, r[15:0]};
        4:       a = r;
        default: a = r[0] ? 32'h0000_2FFF : 32'h0000_0000;
      endcase
      xfer(a, 1'($urandom), $urandom, int'($urandom_range(0, 3)), $urandom,
           1'($urandom), "rand");
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
